// File: rtl/regdest_pkg.sv
// regdest_pkg: shared select codes, FSM states and default
// register indices for the register-write destination unit.
package regdest_pkg;

  localparam logic [2:0] SEL_RT = 3'd0;
  localparam logic [2:0] SEL_RS = 3'd1;
  localparam logic [2:0] SEL_SP = 3'd2;
  localparam logic [2:0] SEL_RA = 3'd3;
  localparam logic [2:0] SEL_RD = 3'd4;

  localparam int DEF_SP_REG = 29;
  localparam int DEF_RA_REG = 31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR0  = 2'd1,
    ST_WR1  = 2'd2
  } state_t;

endpackage

// File: rtl/regdest_decode.sv
// regdest_decode: combinational destination select.
// Reserved select codes resolve to $zero.
module regdest_decode
  import regdest_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int SP_REG = DEF_SP_REG,
  parameter int RA_REG = DEF_RA_REG
) (
  input  logic [2:0]        sel,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rd,
  output logic [ADDR_W-1:0] addr
);

  always_comb begin
    addr = '0;
    case (sel)
      SEL_RT:  addr = rt;
      SEL_RS:  addr = rs;
      SEL_SP:  addr = ADDR_W'(SP_REG);
      SEL_RA:  addr = ADDR_W'(RA_REG);
      SEL_RD:  addr = rd;
      default: addr = '0;
    endcase
  end

endmodule

// File: rtl/regdest_seq.sv
// regdest_seq: sequenced register-bank write unit with optional
// $sp second write. Hazard hits enabled by REGDEST_FWD_EN.
module regdest_seq
  import regdest_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int SP_REG = DEF_SP_REG,
  parameter int RA_REG = DEF_RA_REG
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        sel,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rd,
  input  logic              start,
  input  logic              dual,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  input  logic              hold,
  output logic              reg_we,
  output logic [ADDR_W-1:0] reg_waddr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              busy,
  output logic              done,
  output logic              hit_a,
  output logic              hit_b,
  input  logic [ADDR_W-1:0] qa,
  input  logic [ADDR_W-1:0] qb
);

  localparam logic [ADDR_W-1:0] SP_A = ADDR_W'(SP_REG);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr0;
  logic [DATA_W-1:0] r_data0;
  logic [DATA_W-1:0] r_data1;
  logic              r_dual;
  logic [ADDR_W-1:0] w_dec;

  regdest_decode #(
    .ADDR_W(ADDR_W),
    .SP_REG(SP_REG),
    .RA_REG(RA_REG)
  ) u_dec (
    .sel (sel),
    .rt  (rt),
    .rs  (rs),
    .rd  (rd),
    .addr(w_dec)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_addr0 <= '0;
      r_data0 <= '0;
      r_data1 <= '0;
      r_dual  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: if (start) begin
          r_state <= ST_WR0;
          r_addr0 <= w_dec;
          r_data0 <= data0;
          r_data1 <= data1;
          r_dual  <= dual;
        end
        ST_WR0: if (!hold)
          r_state <= r_dual ? ST_WR1 : ST_IDLE;
        ST_WR1: if (!hold)
          r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // hold is the only live input allowed to gate the write strobe
  always_comb begin
    reg_we    = 1'b0;
    reg_waddr = '0;
    reg_wdata = '0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (r_state)
      ST_WR0: begin
        busy      = 1'b1;
        reg_waddr = r_addr0;
        reg_wdata = r_data0;
        reg_we    = !hold && (r_addr0 != '0);
        done      = !hold && !r_dual;
      end
      ST_WR1: begin
        busy      = 1'b1;
        reg_waddr = SP_A;
        reg_wdata = r_data1;
        reg_we    = !hold;
        done      = !hold;
      end
      default: ;
    endcase
  end

`ifdef REGDEST_FWD_EN
  logic w_sp_pend;
  assign w_sp_pend = (r_state == ST_WR1) ||
                     (r_state == ST_WR0 && r_dual);

  assign hit_a = busy && (qa != '0) &&
                 ((qa == reg_waddr) ||
                  (w_sp_pend && qa == SP_A));
  assign hit_b = busy && (qb != '0) &&
                 ((qb == reg_waddr) ||
                  (w_sp_pend && qb == SP_A));
`else
  assign hit_a = 1'b0 & (|qa);
  assign hit_b = 1'b0 & (|qb);
`endif

endmodule

// File: tb/tb_regdest_seq.sv
// tb_regdest_seq: directed plus random stimulus against a
// queue-of-pending-writes reference model.
module tb_regdest_seq;

  logic        clk = 1'b0;
  logic        reset, start, dual, hold;
  logic [2:0]  sel;
  logic [4:0]  rt, rs, rd, qa, qb;
  logic [31:0] data0, data1;
  logic        reg_we, busy, done, hit_a, hit_b;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    bit          last;
  } step_t;

  step_t mq[$];

  always #5 clk = ~clk;

  regdest_seq dut (
    .clk      (clk),
    .reset    (reset),
    .sel      (sel),
    .rt       (rt),
    .rs       (rs),
    .rd       (rd),
    .start    (start),
    .dual     (dual),
    .data0    (data0),
    .data1    (data1),
    .hold     (hold),
    .reg_we   (reg_we),
    .reg_waddr(reg_waddr),
    .reg_wdata(reg_wdata),
    .busy     (busy),
    .done     (done),
    .hit_a    (hit_a),
    .hit_b    (hit_b),
    .qa       (qa),
    .qb       (qb)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h @%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] dec(input logic [2:0] s);
    case (s)
      3'd0:    return rt;
      3'd1:    return rs;
      3'd2:    return 5'd29;
      3'd3:    return 5'd31;
      3'd4:    return rd;
      default: return 5'd0;
    endcase
  endfunction

  function automatic bit pend(input logic [4:0] q);
    if (q == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i].a == q) return 1'b1;
    return 1'b0;
  endfunction

  // Compare mid-cycle, then advance the model on the edge.
  task automatic tick();
    bit e_we, e_done, e_busy, e_ha, e_hb;
    logic [4:0]  e_a;
    logic [31:0] e_d;
    #3;
    e_busy = mq.size() != 0;
    e_we = 0; e_done = 0; e_a = 0; e_d = 0;
    e_ha = 0; e_hb = 0;
    if (e_busy) begin
      e_a = mq[0].a;
      e_d = mq[0].d;
      e_we = !hold && (e_a != 0);
      e_done = !hold && mq[0].last;
`ifdef REGDEST_FWD_EN
      e_ha = pend(qa);
      e_hb = pend(qb);
`endif
    end
    chk("we",    32'(reg_we),    32'(e_we));
    chk("waddr", 32'(reg_waddr), 32'(e_a));
    chk("wdata", reg_wdata,      e_d);
    chk("busy",  32'(busy),      32'(e_busy));
    chk("done",  32'(done),      32'(e_done));
    chk("hit_a", 32'(hit_a),     32'(e_ha));
    chk("hit_b", 32'(hit_b),     32'(e_hb));
    @(posedge clk);
    if (reset) mq.delete();
    else if (mq.size() == 0) begin
      if (start) begin
        mq.push_back('{dec(sel), data0, !dual});
        if (dual) mq.push_back('{5'd29, data1, 1'b1});
      end
    end else if (!hold) void'(mq.pop_front());
    #1;
  endtask

  task automatic go(input logic [2:0] s,
                    input bit du,
                    input logic [31:0] d0,
                    input logic [31:0] d1);
    sel = s; dual = du; data0 = d0; data1 = d1;
    start = 1'b1;
    tick();
    start = 1'b0;
    sel = 3'($urandom);
    rt = 5'($urandom); rs = 5'($urandom); rd = 5'($urandom);
    data0 = $urandom; data1 = $urandom;
  endtask

  initial begin
    reset = 1; start = 0; dual = 0; hold = 0;
    sel = 0; rt = 0; rs = 0; rd = 0; qa = 0; qb = 0;
    data0 = 0; data1 = 0;
    repeat (2) @(posedge clk);
    #1;
    tick();
    reset = 0;
    tick();

    rd = 5'd9; qa = 5'd9; qb = 5'd0;
    go(3'd4, 1'b0, 32'hDEADBEEF, 32'h0);
    tick();
    tick();

    rt = 5'd8; qa = 5'd29;
    go(3'd0, 1'b1, 32'h11, 32'h7FFC);
    tick();
    tick();
    tick();

    rt = 5'd8;
    go(3'd0, 1'b1, 32'h22, 32'h7FF8);
    hold = 1;
    tick();
    tick();
    hold = 0;
    tick();
    tick();
    tick();

    rt = 5'd0;
    go(3'd0, 1'b0, 32'h33, 32'h0);
    tick();
    go(3'd6, 1'b0, 32'h44, 32'h0);
    tick();

    rs = 5'd12;
    go(3'd1, 1'b1, 32'h55, 32'h66);
    tick();
    reset = 1; hold = 1;
    tick();
    reset = 0; hold = 0;
    tick();
    go(3'd3, 1'b0, 32'h77, 32'h0);
    tick();
    tick();

    repeat (1500) begin
      reset = ($urandom_range(0, 59) == 0);
      start = ($urandom_range(0, 2) == 0);
      dual  = 1'($urandom);
      hold  = ($urandom_range(0, 3) == 0);
      sel   = 3'($urandom);
      rt = 5'($urandom); rs = 5'($urandom); rd = 5'($urandom);
      data0 = $urandom; data1 = $urandom;
      case ($urandom_range(0, 3))
        0: qa = 5'd29;
        1: qa = mq.size() != 0 ? mq[0].a : 5'd0;
        default: qa = 5'($urandom);
      endcase
      qb = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
